// File: rtl/mtl_fb_pkg.sv
// Shared definitions for the MTL frame-buffer arbiter: default widths,
// the arbitration state encoding and the starvation counter width.
package mtl_fb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 32;

    // Starvation counter width; STARVE_LIM is capped at 255 so 8 bits suffice.
    localparam int CNT_W = 8;

    // NORMAL: display reads win. FORCE_WR: one write slot is handed out
    // regardless of the display request, then back to NORMAL.
    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_WR = 1'b1
    } arb_state_t;

    // Width of a writer index; at least one bit even for degenerate N.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mtl_fb_arbiter_rr.sv
// Combinational round-robin picker. Given the request vector and the index
// of the last granted requester, returns a one-hot grant for the first
// requester found searching upward from ptr+1, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the N candidates in priority order starting after the pointer.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = PTR_W'((int'(ptr) + off) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mtl_fb_arbiter.sv
// Single-port frame-buffer arbiter for the MTL display path. One synchronous
// memory port is shared between the display pixel fetcher (reads, strict
// priority) and N_WR write requesters served round-robin. A starvation
// counter forces one write slot when writers have been blocked too long.
//
// Handshake (both read and write sides): a requester raises its REQ and
// holds REQ plus address/data stable until it sees its GNT. GNT is
// combinational in the same cycle; a transfer happens in exactly the cycle
// where REQ and GNT are both high, and the requester may drop or change
// REQ on the following cycle. Grants look only at the current REQ, so a
// request withdrawn in a cycle is never granted in that cycle.
module mtl_fb_arbiter
    import mtl_fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N_WR       = 2,
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 16
) (
    input  logic                     iCLK,
    input  logic                     iRSTN,

    input  logic                     iRD_REQ,
    input  logic [ADDR_W-1:0]        iRD_ADDR,
    output logic                     oRD_GNT,
    output logic [DATA_W-1:0]        oRD_DATA,
    output logic                     oRD_VALID,

    input  logic [N_WR-1:0]          iWR_REQ,
    input  logic [N_WR*ADDR_W-1:0]   iWR_ADDR,
    input  logic [N_WR*DATA_W-1:0]   iWR_DATA,
    output logic [N_WR-1:0]          oWR_GNT,

    output logic [ADDR_W-1:0]        oMEM_ADDR,
    output logic [DATA_W-1:0]        oMEM_WDATA,
    output logic                     oMEM_WE,
    output logic                     oMEM_RE,
    input  logic [DATA_W-1:0]        iMEM_RDATA,

    output arb_state_t               oDBG_STATE
);

    localparam int               PTR_W    = ptr_width(N_WR);
    // The counter value seen in the last blocked cycle before a forced slot:
    // the increment out of this value lands on STARVE_LIM-1.
    localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(STARVE_LIM - 2);
    // Pointer parks on the last writer so writer 0 is searched first.
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_WR - 1);

    // Elaboration-time guards on the supported parameter ranges.
    if (N_WR < 2 || N_WR > 4) begin : g_bad_n_wr
        $error("mtl_fb_arbiter: N_WR must be 2..4");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mtl_fb_arbiter: RD_LAT must be 1..4");
    end
    if (STARVE_LIM < 2 || STARVE_LIM > 255) begin : g_bad_starve
        $error("mtl_fb_arbiter: STARVE_LIM must be 2..255");
    end

    arb_state_t        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [PTR_W-1:0]  rr_ptr;

    logic [N_WR-1:0]   rr_pick;
    logic              wr_pending;
    logic              wr_any;
    logic              wr_blocked;
    logic [PTR_W-1:0]  wr_idx;

    logic [ADDR_W-1:0] wr_addr_a [N_WR];
    logic [DATA_W-1:0] wr_data_a [N_WR];

    // Bit k set means a read granted k+1 cycles ago is still in flight.
    logic [RD_LAT:0]   rd_pipe;

    // Split the flat per-writer buses into indexable arrays.
    for (genvar i = 0; i < N_WR; i++) begin : g_unpack
        assign wr_addr_a[i] = iWR_ADDR[i*ADDR_W +: ADDR_W];
        assign wr_data_a[i] = iWR_DATA[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N     (N_WR),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (iWR_REQ),
        .ptr (rr_ptr),
        .gnt (rr_pick)
    );

    assign wr_pending = |iWR_REQ;
    assign wr_any     = |oWR_GNT;
    assign wr_blocked = wr_pending && !wr_any;
    assign oDBG_STATE = state;

    // Grant decision: forced write slot first, then display, then writers.
    // A forced slot with no writer waiting falls through to the display.
    always_comb begin
        oRD_GNT = 1'b0;
        oWR_GNT = '0;
        if (state == FORCE_WR && wr_pending) begin
            oWR_GNT = rr_pick;
        end else if (iRD_REQ) begin
            oRD_GNT = 1'b1;
        end else begin
            oWR_GNT = rr_pick;
        end
    end

    // Encode the one-hot write grant into the winning writer index.
    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (oWR_GNT[i]) begin
                wr_idx = PTR_W'(i);
            end
        end
    end

    // Arbitration FSM with its round-robin pointer and starvation counter.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            rr_ptr     <= PTR_RST;
        end else begin
            if (wr_any) begin
                rr_ptr <= wr_idx;
            end

            if (wr_blocked) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            // A forced slot lasts exactly one cycle whatever it grants.
            if (wr_blocked && starve_cnt == FORCE_AT) begin
                state <= FORCE_WR;
            end else begin
                state <= NORMAL;
            end
        end
    end

    // Register the granted command onto the memory port one cycle later.
    // Address and write data hold their last values when nothing is granted.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oMEM_ADDR  <= '0;
            oMEM_WDATA <= '0;
            oMEM_WE    <= 1'b0;
            oMEM_RE    <= 1'b0;
        end else begin
            oMEM_WE <= wr_any;
            oMEM_RE <= oRD_GNT;
            if (oRD_GNT) begin
                oMEM_ADDR <= iRD_ADDR;
            end else if (wr_any) begin
                oMEM_ADDR  <= wr_addr_a[wr_idx];
                oMEM_WDATA <= wr_data_a[wr_idx];
            end
        end
    end

    // Track in-flight reads and capture the memory word when it lands.
    // Reset empties the pipe so pre-reset reads never return.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            rd_pipe   <= '0;
            oRD_DATA  <= '0;
            oRD_VALID <= 1'b0;
        end else begin
            rd_pipe   <= {rd_pipe[RD_LAT-1:0], oRD_GNT};
            oRD_VALID <= rd_pipe[RD_LAT];
            if (rd_pipe[RD_LAT]) begin
                oRD_DATA <= iMEM_RDATA;
            end
        end
    end

endmodule

// File: doc/mtl_fb_arbiter.md
# mtl_fb_arbiter

Single-port frame-buffer memory arbiter for the MTL display path. It shares one synchronous memory port between the display pixel fetcher (read, latency-critical) and N_WR write requesters, such as the SPI pixel loader and the overlay/status writer. Display reads have strict priority over writes. Writers are served round-robin, and a starvation guard forces a write slot after STARVE_LIM cycles of blocking. The block sits between the SPI/MTL logic and the frame-buffer RAM, in the iCLK domain.

## Interface
- ADDR_W, 19: frame-buffer word address width
- DATA_W, 32: memory word width
- N_WR, 2: number of write requesters (2..4)
- RD_LAT, 2: memory read latency in cycles from oMEM_RE to iMEM_RDATA valid (1..4)
- STARVE_LIM, 16: count of consecutive blocked write-cycles that forces a write slot (2..255)

Ports:
- iCLK  in  1  clock
- iRSTN  in  1  reset, asynchronous, active-low
- iRD_REQ  in  1  display read request; held until granted
- iRD_ADDR  in  ADDR_W  read address
- oRD_GNT  out  1  read accepted this cycle (combinational)
- oRD_DATA  out  DATA_W  returned read word (registered)
- oRD_VALID  out  1  oRD_DATA valid, one-cycle pulse per grant
- iWR_REQ  in  N_WR  write requests; each held until granted
- iWR_ADDR  in  N_WR×ADDR_W  per-requester write address
- iWR_DATA  in  N_WR×DATA_W  per-requester write data
- oWR_GNT  out  N_WR  one-hot write accept (combinational)
- oMEM_ADDR  out  ADDR_W  memory address (registered)
- oMEM_WDATA  out  DATA_W  memory write data (registered)
- oMEM_WE  out  1  memory write strobe
- oMEM_RE  out  1  memory read strobe
- iMEM_RDATA  in  DATA_W  memory read data

## Operation
- At most one grant per cycle. oRD_GNT and oWR_GNT are mutually exclusive, and oWR_GNT is always one-hot or zero.
- State NORMAL:
  - If iRD_REQ is high, the display is granted.
  - Otherwise the round-robin pick among iWR_REQ is granted.
- State FORCE_WR:
  - The round-robin pick among iWR_REQ is granted even if iRD_REQ is high.
  - The state returns to NORMAL on the next cycle.
- Round-robin pointer:
  - Holds the index of the last-granted writer. The search starts at pointer+1 mod N_WR.
  - It updates only on a write grant.
- Starvation counter (8-bit):
  - Increments each cycle in which |iWR_REQ is high and no write is granted.
  - Clears on any write grant, or when |iWR_REQ is low.
  - When it reaches STARVE_LIM-1 while still blocked, the state goes to FORCE_WR.
- Memory command:
  - A grant in cycle t registers oMEM_ADDR/oMEM_WDATA and pulses oMEM_WE or oMEM_RE in cycle t+1.
  - With no grant, both strobes are 0 and addr/data hold their previous values.
- Read return:
  - A RD_LAT+1-deep valid shift register tracks in-flight reads.
  - When the tail is set, iMEM_RDATA is registered into oRD_DATA and oRD_VALID pulses.
- Back-to-back reads issue every cycle, so throughput is one word per cycle.

## Timing
- Reset values:
  - All registered outputs are 0: oMEM_*, oRD_DATA, oRD_VALID.
  - The read-valid pipe is cleared, the state is NORMAL, and the counter is 0.
  - The pointer is N_WR-1, so writer 0 has first priority.
- Read latency: oRD_GNT at cycle t, then oMEM_RE at t+1, iMEM_RDATA at t+1+RD_LAT, and oRD_VALID at t+2+RD_LAT.
- Write latency: oWR_GNT at t, then oMEM_WE at t+1.
- Worst-case write wait: with a continuous display request, some writer is granted within STARVE_LIM cycles. Each individual writer is granted within N_WR×STARVE_LIM cycles.
- Simultaneous events:
  - A request dropped in the same cycle its grant would fire is not granted. Grants depend on the current request only.
  - FORCE_WR with all iWR_REQ low issues no grant that cycle, the display is granted, and the state returns to NORMAL.
- Reset mid-operation: reads in flight are discarded, so no oRD_VALID appears after reset release for pre-reset grants. The memory strobes deassert immediately, asynchronously.

## Structure
- Package mtl_fb_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - the state enum typedef arb_state_t {NORMAL, FORCE_WR};
  - the counter width constant.
- Sub-module rr_arbiter (parameter N) computes the one-hot round-robin pick from the request vector and pointer. It is purely combinational; the pointer register lives in mtl_fb_arbiter.

## Test plan
- Reads only: iRD_REQ held 4 cycles, addresses 0..3, RD_LAT=2. Expect oMEM_RE on cycles 1..4 and oRD_VALID on cycles 4..7, with data matching the memory model at addresses 0..3.
- Fairness: both writers request continuously with no reads. Expect oWR_GNT = 01,10,01,10…, starting with writer 0 after reset.
- Starvation: iRD_REQ held continuously, writer 1 requests with STARVE_LIM=16. Expect writer 1 granted within 16 cycles, with oRD_GNT low in exactly that one cycle.
- Collision: iRD_REQ and iWR_REQ[0] both rise in the same cycle with the counter at 0. Expect the read granted first and the write granted on the next cycle after iRD_REQ drops.
- Reset mid-read: assert iRSTN low 1 cycle after a read grant. Expect all outputs 0 and no oRD_VALID ever for that grant.
